// File: rtl/keccakp400_inv_core.sv
// keccakp400_inv_core
//   Iterative inverse Keccak-p[400]. Undoes the last R forward rounds
//   (forward index r = R..1, round constant RC[20-r]) by running inverse
//   rounds r = 1..R. Each inverse round takes three cycles:
//     S_CHI   : iota^-1 on lane (0,0), then chi^-1 on every 5-bit row
//     S_PIRHO : pi^-1, then rho^-1 (rotate right)
//     S_THETA : theta^-1 via a constant (I+M)^-1 matrix on column parities
//
// Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. Input is taken only in IDLE (in_ready_o = IDLE). The result
//   is held in DONE with out_valid_o high and state_o stable until
//   out_ready_i is seen; the FSM then returns to IDLE, so the next input is
//   accepted no earlier than the following cycle.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   state_i       400-bit input state, bit 16*(5*y+x)+i = lane (x,y) bit i
//   rounds_i      inverse round count, saturated to NR_MAX at accept
//   in_valid_i    input valid
//   in_ready_o    input ready (decoded from FSM state)
//   state_o       registered result state, same lane order
//   out_valid_o   registered result valid
//   out_ready_i   output ready
//   dbg_state_o   current FSM state encoding for observation
module keccakp400_inv_core #(
  parameter int NR_MAX = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [399:0] state_i,
  input  logic [4:0]   rounds_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [399:0] state_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [2:0]   dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    S_CHI   = 3'd1,
    S_PIRHO = 3'd2,
    S_THETA = 3'd3,
    DONE    = 3'd4
  } fsm_t;

  // Rho offsets indexed by 5*y+x; only the low four bits matter for 16-bit lanes.
  localparam int RHO_OFF [25] = '{
     0,  1, 62, 28, 27,
    36, 44,  6, 55, 20,
     3, 10, 43, 25, 39,
    41, 45, 15, 21,  8,
    18,  2, 61, 56, 14
  };

  // Inverse chi row table: entry chi(a) holds a.
  function automatic logic [31:0][4:0] chi_inv_table();
    logic [31:0][4:0] t;
    logic [4:0]       a;
    logic [4:0]       b;
    t = '0;
    for (int v = 0; v < 32; v++) begin
      a = v[4:0];
      for (int x = 0; x < 5; x++)
        b[x] = a[x] ^ (~a[(x + 1) % 5] & a[(x + 2) % 5]);
      t[b] = a;
    end
    return t;
  endfunction

  // Forward theta maps column parity C to C' = (I+M)C with
  // (MC)[x][z] = C[x-1][z] ^ C[x+1][z-1]. Gauss-Jordan on [I+M | I]
  // leaves (I+M)^-1 in the right half; row r gives C bit r as a parity mask.
  function automatic logic [79:0][79:0] theta_inv_matrix();
    logic [79:0][79:0] a;
    logic [79:0][79:0] b;
    logic [79:0]       tmp;
    logic              found;
    int                p;
    int                x;
    int                z;
    for (int r = 0; r < 80; r++) begin
      x = r / 16;
      z = r % 16;
      a[r] = '0;
      b[r] = '0;
      b[r][r] = 1'b1;
      a[r][r] = 1'b1;
      a[r][16 * ((x + 4) % 5) + z] = a[r][16 * ((x + 4) % 5) + z] ^ 1'b1;
      a[r][16 * ((x + 1) % 5) + ((z + 15) % 16)] =
        a[r][16 * ((x + 1) % 5) + ((z + 15) % 16)] ^ 1'b1;
    end
    for (int c = 0; c < 80; c++) begin
      found = 1'b0;
      p = c;
      for (int r = c; r < 80; r++) begin
        if (!found && a[r][c]) begin
          found = 1'b1;
          p = r;
        end
      end
      tmp = a[c]; a[c] = a[p]; a[p] = tmp;
      tmp = b[c]; b[c] = b[p]; b[p] = tmp;
      for (int r = 0; r < 80; r++) begin
        if (r != c && a[r][c]) begin
          a[r] = a[r] ^ a[c];
          b[r] = b[r] ^ b[c];
        end
      end
    end
    return b;
  endfunction

  localparam logic [31:0][4:0]  CHI_INV   = chi_inv_table();
  localparam logic [79:0][79:0] THETA_INV = theta_inv_matrix();

  function automatic logic [15:0] rc_lookup(input logic [4:0] idx);
    case (idx)
      5'd0:  return 16'h0001;
      5'd1:  return 16'h8082;
      5'd2:  return 16'h808A;
      5'd3:  return 16'h8000;
      5'd4:  return 16'h808B;
      5'd5:  return 16'h0001;
      5'd6:  return 16'h8081;
      5'd7:  return 16'h8009;
      5'd8:  return 16'h008A;
      5'd9:  return 16'h0088;
      5'd10: return 16'h8009;
      5'd11: return 16'h000A;
      5'd12: return 16'h808B;
      5'd13: return 16'h008B;
      5'd14: return 16'h8089;
      5'd15: return 16'h8003;
      5'd16: return 16'h8002;
      5'd17: return 16'h0080;
      5'd18: return 16'h800A;
      5'd19: return 16'h000A;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] lane_rotr(input logic [15:0] v, input int n);
    logic [15:0] o;
    for (int i = 0; i < 16; i++) o[i] = v[(i + n) % 16];
    return o;
  endfunction

  function automatic logic [399:0] chi_step(input logic [399:0] s, input logic [15:0] rc);
    logic [399:0] t;
    logic [399:0] o;
    logic [4:0]   row;
    logic [4:0]   inv;
    t = s;
    t[15:0] = s[15:0] ^ rc;
    o = '0;
    for (int y = 0; y < 5; y++) begin
      for (int i = 0; i < 16; i++) begin
        for (int x = 0; x < 5; x++) row[x] = t[16 * (5 * y + x) + i];
        inv = CHI_INV[row];
        for (int x = 0; x < 5; x++) o[16 * (5 * y + x) + i] = inv[x];
      end
    end
    return o;
  endfunction

  // Lane (x,y) comes from lane (y, (2x+3y) mod 5), then rotates right.
  function automatic logic [399:0] pirho_step(input logic [399:0] s);
    logic [399:0] o;
    int           src;
    o = '0;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        src = 5 * ((2 * x + 3 * y) % 5) + y;
        o[16 * (5 * y + x) +: 16] = lane_rotr(s[16 * src +: 16], RHO_OFF[5 * y + x] % 16);
      end
    end
    return o;
  endfunction

  function automatic logic [399:0] theta_step(input logic [399:0] s);
    logic [399:0] o;
    logic [79:0]  cp;
    logic [79:0]  c;
    logic [15:0]  d;
    cp = '0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        cp[16 * x +: 16] = cp[16 * x +: 16] ^ s[16 * (5 * y + x) +: 16];
    for (int r = 0; r < 80; r++) c[r] = ^(THETA_INV[r] & cp);
    o = s;
    for (int x = 0; x < 5; x++) begin
      for (int z = 0; z < 16; z++)
        d[z] = c[16 * ((x + 4) % 5) + z] ^ c[16 * ((x + 1) % 5) + ((z + 15) % 16)];
      for (int y = 0; y < 5; y++)
        o[16 * (5 * y + x) +: 16] = s[16 * (5 * y + x) +: 16] ^ d;
    end
    return o;
  endfunction

  fsm_t         state_q, state_d;
  logic [399:0] st_q, st_d;
  logic [4:0]   r_q, r_d;
  logic [4:0]   r_max_q, r_max_d;
  logic         out_valid_q;
  logic [4:0]   rounds_sat;
  logic [4:0]   rc_idx;

  assign rounds_sat = (rounds_i > 5'(NR_MAX)) ? 5'(NR_MAX) : rounds_i;
  assign rc_idx     = 5'(NR_MAX) - r_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid_i) state_d = (rounds_sat == 5'd0) ? DONE : S_CHI;
      S_CHI:   state_d = S_PIRHO;
      S_PIRHO: state_d = S_THETA;
      S_THETA: state_d = (r_q < r_max_q) ? S_CHI : DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready_o  = (state_q == IDLE);
    dbg_state_o = state_q;
    state_o     = st_q;
    out_valid_o = out_valid_q;
  end

  // Datapath next values
  always_comb begin
    st_d    = st_q;
    r_d     = r_q;
    r_max_d = r_max_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          st_d    = state_i;
          r_d     = 5'd1;
          r_max_d = rounds_sat;
        end
      end
      S_CHI:   st_d = chi_step(st_q, rc_lookup(rc_idx));
      S_PIRHO: st_d = pirho_step(st_q);
      S_THETA: begin
        st_d = theta_step(st_q);
        if (r_q < r_max_q) r_d = r_q + 5'd1;
      end
      default: ;
    endcase
  end

  // Datapath registers; valid is registered from the next state so it
  // tracks DONE exactly without a combinational path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= '0;
      r_q         <= '0;
      r_max_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      st_q        <= st_d;
      r_q         <= r_d;
      r_max_q     <= r_max_d;
      out_valid_q <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_keccakp400_inv_core.sv
// Testbench for keccakp400_inv_core: directed steps with a forward
// Keccak-p[400] reference used to build inputs whose inverse is known.
module tb_keccakp400_inv_core;

  logic         clk = 1'b0;
  logic         rst;
  logic [399:0] state_i;
  logic [4:0]   rounds_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [399:0] state_o;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [2:0]   dbg_state_o;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  logic [399:0] exp_q[$];

  keccakp400_inv_core #(.NR_MAX(20)) dut (
    .clk         (clk),
    .rst         (rst),
    .state_i     (state_i),
    .rounds_i    (rounds_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .state_o     (state_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .dbg_state_o (dbg_state_o)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam int RHO [25] = '{
     0,  1, 62, 28, 27,
    36, 44,  6, 55, 20,
     3, 10, 43, 25, 39,
    41, 45, 15, 21,  8,
    18,  2, 61, 56, 14
  };

  function automatic logic [15:0] rc_of(input int idx);
    case (idx)
      0: return 16'h0001;  1: return 16'h8082;  2: return 16'h808A;  3: return 16'h8000;
      4: return 16'h808B;  5: return 16'h0001;  6: return 16'h8081;  7: return 16'h8009;
      8: return 16'h008A;  9: return 16'h0088; 10: return 16'h8009; 11: return 16'h000A;
     12: return 16'h808B; 13: return 16'h008B; 14: return 16'h8089; 15: return 16'h8003;
     16: return 16'h8002; 17: return 16'h0080; 18: return 16'h800A; 19: return 16'h000A;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] rotl16(input logic [15:0] v, input int n);
    logic [15:0] o;
    for (int i = 0; i < 16; i++) o[i] = v[(i + 16 - n) % 16];
    return o;
  endfunction

  // One forward round: theta, rho, pi, chi, iota.
  function automatic logic [399:0] fwd_round(input logic [399:0] s, input logic [15:0] rc);
    logic [15:0]  a [5][5];
    logic [15:0]  b [5][5];
    logic [15:0]  c [5];
    logic [15:0]  d [5];
    logic [399:0] o;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        a[x][y] = s[16 * (5 * y + x) +: 16];
    for (int x = 0; x < 5; x++) begin
      c[x] = 16'h0;
      for (int y = 0; y < 5; y++) c[x] = c[x] ^ a[x][y];
    end
    for (int x = 0; x < 5; x++) d[x] = c[(x + 4) % 5] ^ rotl16(c[(x + 1) % 5], 1);
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        a[x][y] = a[x][y] ^ d[x];
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        b[y][(2 * x + 3 * y) % 5] = rotl16(a[x][y], RHO[5 * y + x] % 16);
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        a[x][y] = b[x][y] ^ (~b[(x + 1) % 5][y] & b[(x + 2) % 5][y]);
    a[0][0] = a[0][0] ^ rc;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        o[16 * (5 * y + x) +: 16] = a[x][y];
    return o;
  endfunction

  // Forward rounds r = R down to 1.
  function automatic logic [399:0] fwd_perm(input logic [399:0] s, input int nr);
    logic [399:0] t;
    t = s;
    for (int r = nr; r >= 1; r--) t = fwd_round(t, rc_of(20 - r));
    return t;
  endfunction

  function automatic logic [399:0] rand400();
    logic [415:0] t;
    for (int i = 0; i < 13; i++) t[32 * i +: 32] = $urandom;
    return t[399:0];
  endfunction

  task automatic check(input string tag, input logic [399:0] obs, input logic [399:0] req);
    assert_cnt++;
    assert (obs === req) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  // Drivers. All start and end just after a falling edge.
  task automatic start_job(input logic [399:0] s, input logic [4:0] r);
    check("ready_before_accept", in_ready_o, 1'b1);
    state_i    = s;
    rounds_i   = r;
    in_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_i = 1'b0;
  endtask

  task automatic wait_valid(inout int lat);
    while (!out_valid_o && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_out();
    out_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready_i = 1'b0;
  endtask

  task automatic run_job(input string tag, input logic [399:0] s, input logic [4:0] r,
                         input logic [399:0] expv, input int exp_lat);
    int lat;
    exp_q.push_back(expv);
    start_job(s, r);
    lat = 1;
    wait_valid(lat);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_state"}, state_o, exp_q.pop_front());
    finish_out();
  endtask

  initial begin
    logic [399:0] x;
    logic [399:0] x2;
    int           lat;
    int           nr;

    rst         = 1'b1;
    state_i     = '0;
    rounds_i    = '0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid_o, 1'b0);
    check("rst_state_o", state_o, '0);
    check("rst_in_ready", in_ready_o, 1'b1);
    check("rst_dbg_state", dbg_state_o, 3'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready_o, 1'b1);
    check("idle_out_valid", out_valid_o, 1'b0);

    // Zero vector: RC[19] = 0x000A cancels the only set bits.
    run_job("zero_vec", 400'h000A, 5'd1, 400'h0, 4);

    // R = 0 passes the state through
    x = rand400();
    run_job("r0", x, 5'd0, x, 1);

    // Round trips
    for (int n = 0; n < 200; n++) begin
      nr = (n % 3 == 0) ? 1 : ((n % 3 == 1) ? 12 : 20);
      x = rand400();
      run_job("round_trip", fwd_perm(x, nr), nr[4:0], x, 3 * nr + 1);
    end

    // Saturation with backpressure
    x = rand400();
    exp_q.push_back(x);
    start_job(fwd_perm(x, 20), 5'd31);
    lat = 1;
    wait_valid(lat);
    check("sat_latency", lat, 61);
    x2 = exp_q.pop_front();
    for (int k = 0; k < 10; k++) begin
      check("bp_state", state_o, x2);
      check("bp_out_valid", out_valid_o, 1'b1);
      check("bp_in_ready", in_ready_o, 1'b0);
      check("bp_dbg_state", dbg_state_o, 3'd4);
      @(negedge clk);
    end
    finish_out();

    // Input pulses during a busy run are ignored
    x = rand400();
    exp_q.push_back(x);
    start_job(fwd_perm(x, 12), 5'd12);
    lat = 1;
    repeat (3) begin
      @(negedge clk);
      lat++;
      check("busy_in_ready", in_ready_o, 1'b0);
      state_i    = rand400();
      rounds_i   = 5'd0;
      in_valid_i = 1'b1;
    end
    @(negedge clk);
    lat++;
    in_valid_i = 1'b0;
    wait_valid(lat);
    check("busy_latency", lat, 37);
    check("busy_state", state_o, exp_q.pop_front());

    // New input together with out_ready in DONE: accepted one cycle later
    x2 = rand400();
    exp_q.push_back(x2);
    state_i     = fwd_perm(x2, 1);
    rounds_i    = 5'd1;
    in_valid_i  = 1'b1;
    out_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready_i = 1'b0;
    check("hs_out_valid_dropped", out_valid_o, 1'b0);
    check("hs_idle_ready", in_ready_o, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid_i = 1'b0;
    check("hs_accepted", in_ready_o, 1'b0);
    lat = 1;
    wait_valid(lat);
    check("hs_latency", lat, 4);
    check("hs_state", state_o, exp_q.pop_front());
    finish_out();

    // Reset mid-run
    x = rand400();
    start_job(fwd_perm(x, 20), 5'd20);
    repeat (6) @(negedge clk);
    check("pre_rst_out_valid", out_valid_o, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid_o, 1'b0);
    check("midrst_state_o", state_o, '0);
    check("midrst_in_ready", in_ready_o, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    x = rand400();
    run_job("post_rst", fwd_perm(x, 20), 5'd20, x, 61);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
